fp16_add_wrapper: RTL and testbench

Pipelined IEEE 754 binary16 adder with a valid side-band, one result per cycle at a fixed latency. It is the per-lane adder used by the SSM output stage and other element-wise vector blocks. Lanes built from it rely on identical, deterministic latency so their `valid_out` signals align exactly.

---
 rtl/fp16_pkg.sv | 98 +++++++++
 rtl/fp16_add_wrapper_lzc.sv | 15 +
 rtl/fp16_add_wrapper.sv | 189 ++++++++++++++++++
 tb/tb_fp16_add_wrapper.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared binary16 field constants, canonical encodings and the pipeline
// stage record types used by the fp16 adder.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  // Biased exponent at or above which a finite result becomes infinity.
  localparam logic [EXP_W:0] EXP_INF = (EXP_W + 1)'(2 * BIAS + 1);

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;
  localparam logic [15:0] FP16_NINF = 16'hFC00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // Unpacked operand: subnormals carry exponent 1 and a clear hidden bit.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp16_unp_t;

  // Special-case override travelling down the pipe beside the arithmetic.
  typedef struct packed {
    logic        hit;
    logic [15:0] value;
  } fp16_spec_t;

  typedef struct packed {
    fp16_unp_t a;
    fp16_unp_t b;
  } s1_t;

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic [MAN_W:0]   sig_l;
    logic [MAN_W:0]   sig_s;
    logic [EXP_W-1:0] diff;
    fp16_spec_t       spec;
  } s2_t;

  // Magnitudes are {sig[10:0], guard, round, sticky}.
  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [13:0]      mag_l;
    logic [13:0]      mag_s;
    fp16_spec_t       spec;
  } s3_t;

  typedef struct packed {
    logic           sign;
    logic [EXP_W:0] exp;
    logic [14:0]    sum;
    logic           zero;
    fp16_spec_t     spec;
  } s4_t;

  typedef struct packed {
    logic           sign;
    logic [EXP_W:0] exp;
    logic [13:0]    mant;
    logic           zero;
    fp16_spec_t     spec;
  } s5_t;

  typedef struct packed {
    logic           sign;
    logic [EXP_W:0] exp;
    logic [MAN_W:0] sig;
    logic           zero;
    fp16_spec_t     spec;
  } s6_t;

  function automatic fp16_unp_t fp16_unpack(input fp16_t x);
    fp16_unp_t u;
    u.sign    = x.sign;
    u.exp     = (x.exp == '0) ? EXP_W'(1) : x.exp;
    u.sig     = {x.exp != '0, x.man};
    u.is_nan  = (x.exp == '1) && (x.man != '0);
    u.is_inf  = (x.exp == '1) && (x.man == '0);
    u.is_zero = (x.exp == '0) && (x.man == '0);
    return u;
  endfunction

endpackage

// File: rtl/fp16_add_wrapper_lzc.sv
// Combinational 15-bit leading-zero counter; an all-zero input reports 15.
module fp16_lzc (
  input  logic [14:0] din,
  output logic [3:0]  count
);

  // Scan upward so the highest set bit makes the last assignment.
  always_comb begin
    count = 4'd15;
    for (int i = 0; i < 15; i++) begin
      if (din[i]) count = 4'(14 - i);
    end
  end

endmodule

// File: rtl/fp16_add_wrapper.sv
// Pipelined binary16 adder, RNE, full subnormal support. Seven arithmetic
// stages followed by LAT-7 plain output delay registers; valid rides a
// LAT-bit shift register so every lane built from this has identical latency.
module fp16_add_wrapper #(
  parameter int LAT = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        valid_out
);
  import fp16_pkg::*;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  s4_t s4_d, s4_q;
  s5_t s5_d, s5_q;
  s6_t s6_d, s6_q;

  logic [15:0]    res_d;
  logic [15:0]    res_q [LAT-6];
  logic [LAT-1:0] valid_d, valid_q;

  logic           a_ge_b;
  logic [3:0]     sh;
  logic [26:0]    wide;
  logic [3:0]     lz;
  logic [3:0]     need;
  logic [EXP_W:0] room;
  logic [3:0]     shamt;
  logic [MAN_W:0] sig_t;
  logic           round_up;
  logic [MAN_W+1:0] sig_rnd;

  fp16_lzc u_lzc (
    .din   (s4_q.sum),
    .count (lz)
  );

  // S1: unpack both operands and classify.
  always_comb begin
    s1_d.a = fp16_unpack(fp16_t'(a));
    s1_d.b = fp16_unpack(fp16_t'(b));
  end

  // S2: order by magnitude, take exponent difference, resolve special cases.
  always_comb begin
    s2_d   = '0;
    a_ge_b = {s1_q.a.exp, s1_q.a.sig} >= {s1_q.b.exp, s1_q.b.sig};
    s2_d.sign_l = a_ge_b ? s1_q.a.sign : s1_q.b.sign;
    s2_d.sign_s = a_ge_b ? s1_q.b.sign : s1_q.a.sign;
    s2_d.exp_l  = a_ge_b ? s1_q.a.exp  : s1_q.b.exp;
    s2_d.sig_l  = a_ge_b ? s1_q.a.sig  : s1_q.b.sig;
    s2_d.sig_s  = a_ge_b ? s1_q.b.sig  : s1_q.a.sig;
    s2_d.diff   = a_ge_b ? (s1_q.a.exp - s1_q.b.exp) : (s1_q.b.exp - s1_q.a.exp);
    if (s1_q.a.is_nan || s1_q.b.is_nan) begin
      s2_d.spec = '{hit: 1'b1, value: FP16_QNAN};
    end else if (s1_q.a.is_inf && s1_q.b.is_inf) begin
      s2_d.spec.hit   = 1'b1;
      s2_d.spec.value = (s1_q.a.sign != s1_q.b.sign) ? FP16_QNAN
                      : (s1_q.a.sign ? FP16_NINF : FP16_PINF);
    end else if (s1_q.a.is_inf) begin
      s2_d.spec = '{hit: 1'b1, value: s1_q.a.sign ? FP16_NINF : FP16_PINF};
    end else if (s1_q.b.is_inf) begin
      s2_d.spec = '{hit: 1'b1, value: s1_q.b.sign ? FP16_NINF : FP16_PINF};
    end else if (s1_q.a.is_zero && s1_q.b.is_zero) begin
      // Only (-0)+(-0) keeps the negative sign.
      s2_d.spec = '{hit: 1'b1, value: {s1_q.a.sign & s1_q.b.sign, 15'd0}};
    end
  end

  // S3: align the smaller significand; everything past round folds into sticky.
  always_comb begin
    s3_d         = '0;
    sh           = (s2_q.diff > 5'd14) ? 4'd14 : s2_q.diff[3:0];
    wide         = {s2_q.sig_s, 16'd0} >> sh;
    s3_d.sign    = s2_q.sign_l;
    s3_d.eff_sub = s2_q.sign_l ^ s2_q.sign_s;
    s3_d.exp     = s2_q.exp_l;
    s3_d.mag_l   = {s2_q.sig_l, 3'b000};
    s3_d.mag_s   = {wide[26:14], |wide[13:0]};
    s3_d.spec    = s2_q.spec;
  end

  // S4: magnitude add or subtract; bit 14 is the carry-out.
  always_comb begin
    s4_d      = '0;
    s4_d.sign = s3_q.sign;
    s4_d.exp  = {1'b0, s3_q.exp};
    s4_d.sum  = s3_q.eff_sub ? ({1'b0, s3_q.mag_l} - {1'b0, s3_q.mag_s})
                             : ({1'b0, s3_q.mag_l} + {1'b0, s3_q.mag_s});
    s4_d.zero = (s4_d.sum == '0);
    s4_d.spec = s3_q.spec;
  end

  // S5: normalize; left shifts stop at exponent 1 so small results stay subnormal.
  always_comb begin
    s5_d      = '0;
    need      = lz - 4'd1;
    room      = s4_q.exp - (EXP_W + 1)'(1);
    shamt     = ({2'b00, need} < room) ? need : room[3:0];
    s5_d.sign = s4_q.sign;
    s5_d.zero = s4_q.zero;
    s5_d.spec = s4_q.spec;
    if (s4_q.sum[14]) begin
      s5_d.mant = {s4_q.sum[14:2], s4_q.sum[1] | s4_q.sum[0]};
      s5_d.exp  = s4_q.exp + (EXP_W + 1)'(1);
    end else begin
      s5_d.mant = s4_q.sum[13:0] << shamt;
      s5_d.exp  = s4_q.exp - {2'b00, shamt};
    end
  end

  // S6: round to nearest, ties to even, and renormalize on significand carry.
  always_comb begin
    s6_d      = '0;
    sig_t     = s5_q.mant[13:3];
    round_up  = s5_q.mant[2] & (s5_q.mant[1] | s5_q.mant[0] | sig_t[0]);
    sig_rnd   = {1'b0, sig_t} + (MAN_W + 2)'(round_up);
    s6_d.sign = s5_q.sign;
    s6_d.zero = s5_q.zero;
    s6_d.spec = s5_q.spec;
    if (sig_rnd[MAN_W+1]) begin
      s6_d.sig = sig_rnd[MAN_W+1:1];
      s6_d.exp = s5_q.exp + (EXP_W + 1)'(1);
    end else begin
      s6_d.sig = sig_rnd[MAN_W:0];
      s6_d.exp = s5_q.exp;
    end
  end

  // S7: pack, apply overrides, saturate to infinity. No hidden bit means subnormal.
  always_comb begin
    res_d = '0;
    if (s6_q.spec.hit) begin
      res_d = s6_q.spec.value;
    end else if (s6_q.zero) begin
      res_d = 16'h0000;
    end else if (s6_q.exp >= EXP_INF) begin
      res_d = s6_q.sign ? FP16_NINF : FP16_PINF;
    end else begin
      res_d = {s6_q.sign, s6_q.sig[MAN_W] ? s6_q.exp[EXP_W-1:0] : 5'd0, s6_q.sig[MAN_W-1:0]};
    end
  end

  // Valid side-band shift register.
  always_comb begin
    valid_d = {valid_q[LAT-2:0], valid_in};
  end

  // Arithmetic stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      s4_q <= '0;
      s5_q <= '0;
      s6_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      s4_q <= s4_d;
      s5_q <= s5_d;
      s6_q <= s6_d;
    end
  end

  // Packed result register plus the trailing delay stages, and the valid chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i <= LAT - 7; i++) res_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      res_q[0] <= res_d;
      for (int i = 1; i <= LAT - 7; i++) res_q[i] <= res_q[i-1];
    end
  end

  assign result    = res_q[LAT-7];
  assign valid_out = valid_q[LAT-1];

endmodule

// File: tb/tb_fp16_add_wrapper.sv
// Self-checking bench for fp16_add_wrapper: directed vectors, random streams
// against an exact-integer reference model, latency and reset behaviour.
module tb_fp16_add_wrapper;

  localparam int LAT  = 11;
  localparam int MAXN = 400;
  localparam int CAPN = MAXN + LAT + 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        valid_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        sv [MAXN];
  logic [15:0] sa [MAXN];
  logic [15:0] sb [MAXN];
  logic [15:0] se [MAXN];
  logic        cv [CAPN];
  logic [15:0] cr [CAPN];

  fp16_add_wrapper #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .result    (result),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  // Exact value of a finite binary16 in units of 2^-24.
  function automatic longint fp_val(input logic [15:0] x);
    longint m;
    int     e;
    e = int'(x[14:10]);
    if (e == 0) m = longint'(x[9:0]);
    else        m = longint'({1'b1, x[9:0]}) << (e - 1);
    return x[15] ? -m : m;
  endfunction

  // Reference: exact integer sum, then round-to-nearest-even into binary16.
  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    bit     x_nan, y_nan, x_inf, y_inf, neg;
    longint s, m, q, r, half;
    int     k;
    x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
    if (x_nan || y_nan) return 16'h7E00;
    if (x_inf && y_inf) return (x[15] != y[15]) ? 16'h7E00 : x;
    if (x_inf) return x;
    if (y_inf) return y;
    s = fp_val(x) + fp_val(y);
    if (s == 0) return (x == 16'h8000 && y == 16'h8000) ? 16'h8000 : 16'h0000;
    neg = (s < 0);
    m   = neg ? -s : s;
    if (m < 1024) return {neg, 5'd0, 10'(m)};
    k = 0;
    while ((m >> k) >= 2048) k++;
    q = m >> k;
    r = m - (q << k);
    if (k > 0) begin
      half = longint'(1) << (k - 1);
      if (r > half || (r == half && q[0])) q++;
    end
    if (q == 2048) begin
      q = 1024;
      k++;
    end
    if (k + 1 >= 31) return neg ? 16'hFC00 : 16'h7C00;
    return {neg, 5'(k + 1), 10'(q - 1024)};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0: r[14:10] = 5'd0;
      1: r[14:10] = 5'h1F;
      2: r[14:0]  = 15'd0;
      3: r[14:10] = 5'(29 + $urandom_range(0, 1));
      default: ;
    endcase
    return r;
  endfunction

  task automatic rand_pair(output logic [15:0] x, output logic [15:0] y);
    x = rand_fp();
    if ($urandom_range(0, 3) == 0) y = {~x[15], x[14:0] ^ 15'($urandom_range(0, 3))};
    else                           y = rand_fp();
  endtask

  // Drives sv/sa/sb for n cycles and records outputs; no comparisons here.
  task automatic run_sched(input int n);
    for (int t = 0; t < n + LAT + 2; t++) begin
      @(posedge clk); #1;
      cv[t] = valid_out;
      cr[t] = result;
      if (t < n) begin
        valid_in = sv[t];
        a        = sa[t];
        b        = sb[t];
      end else begin
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_out);
    else pass_cnt++;
    total_cnt++;
    if (result !== 16'h0000) $display("FAIL reset_result: got %h want 0000", result);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    valid_in = 1'b1; a = 16'h3C00; b = 16'h3C00;
    for (int t = 1; t <= LAT + 3; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        valid_in = 1'b0; a = '0; b = '0;
      end
      total_cnt++;
      if (valid_out !== (t == LAT)) $display("FAIL latency_valid t=%0d: got %b want %b", t, valid_out, t == LAT);
      else pass_cnt++;
      if (t == LAT) begin
        total_cnt++;
        if (result !== 16'h4000) $display("FAIL latency_result: got %h want 4000", result);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_directed();
    logic [47:0] vec [14];
    int n;
    vec[0]  = {16'h3C00, 16'hBC00, 16'h0000};
    vec[1]  = {16'h8000, 16'h8000, 16'h8000};
    vec[2]  = {16'h8000, 16'h0000, 16'h0000};
    vec[3]  = {16'h3C00, 16'h1000, 16'h3C00};
    vec[4]  = {16'h3C01, 16'h1000, 16'h3C02};
    vec[5]  = {16'h3C00, 16'h0C00, 16'h3C00};
    vec[6]  = {16'h7BFF, 16'h7BFF, 16'h7C00};
    vec[7]  = {16'h7C00, 16'hFC00, 16'h7E00};
    vec[8]  = {16'h7E01, 16'h3C00, 16'h7E00};
    vec[9]  = {16'hFC00, 16'h4000, 16'hFC00};
    vec[10] = {16'h0001, 16'h0001, 16'h0002};
    vec[11] = {16'h03FF, 16'h0001, 16'h0400};
    vec[12] = {16'h8400, 16'h0200, 16'h8200};
    vec[13] = {16'h3C00, 16'h3C00, 16'h4000};
    n = 28;
    for (int i = 0; i < n; i++) begin
      sv[i] = (i % 2 == 0);
      sa[i] = sv[i] ? vec[i/2][47:32] : 16'h0000;
      sb[i] = sv[i] ? vec[i/2][31:16] : 16'h0000;
      se[i] = vec[i/2][15:0];
    end
    run_sched(n);
    for (int t = 0; t < n + LAT + 2; t++) begin
      logic ev;
      ev = (t >= LAT && t - LAT < n) ? sv[t-LAT] : 1'b0;
      total_cnt++;
      if (cv[t] !== ev) $display("FAIL directed_valid t=%0d: got %b want %b", t, cv[t], ev);
      else pass_cnt++;
      if (ev) begin
        total_cnt++;
        if (cr[t] !== se[t-LAT])
          $display("FAIL directed %h+%h: got %h want %h", sa[t-LAT], sb[t-LAT], cr[t], se[t-LAT]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 43;
    for (int i = 0; i < n; i++) begin
      sv[i] = !(i >= 20 && i < 23);
      rand_pair(sa[i], sb[i]);
    end
    run_sched(n);
    for (int t = 0; t < n + LAT + 2; t++) begin
      logic        ev;
      logic [15:0] er;
      ev = (t >= LAT && t - LAT < n) ? sv[t-LAT] : 1'b0;
      total_cnt++;
      if (cv[t] !== ev) $display("FAIL stream_valid t=%0d: got %b want %b", t, cv[t], ev);
      else pass_cnt++;
      if (ev) begin
        er = ref_add(sa[t-LAT], sb[t-LAT]);
        total_cnt++;
        if (cr[t] !== er) $display("FAIL stream %h+%h: got %h want %h", sa[t-LAT], sb[t-LAT], cr[t], er);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    int n;
    n = 300;
    for (int i = 0; i < n; i++) begin
      sv[i] = ($urandom_range(0, 3) != 0);
      rand_pair(sa[i], sb[i]);
    end
    run_sched(n);
    for (int t = 0; t < n + LAT + 2; t++) begin
      logic        ev;
      logic [15:0] er;
      ev = (t >= LAT && t - LAT < n) ? sv[t-LAT] : 1'b0;
      total_cnt++;
      if (cv[t] !== ev) $display("FAIL random_valid t=%0d: got %b want %b", t, cv[t], ev);
      else pass_cnt++;
      if (ev) begin
        er = ref_add(sa[t-LAT], sb[t-LAT]);
        total_cnt++;
        if (cr[t] !== er) $display("FAIL random %h+%h: got %h want %h", sa[t-LAT], sb[t-LAT], cr[t], er);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      a = 16'h3C00 + 16'(i);
      b = 16'h4000;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++;
    if (result !== 16'h0000) $display("FAIL midreset_result: got %h want 0000", result);
    else pass_cnt++;
    total_cnt++;
    if (valid_out !== 1'b0) $display("FAIL midreset_valid: got %b want 0", valid_out);
    else pass_cnt++;
    valid_in = 1'b1; a = 16'h3C00; b = 16'h4000;
    for (int t = 1; t <= LAT + 3; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        valid_in = 1'b0; a = '0; b = '0;
      end
      total_cnt++;
      if (valid_out !== (t == LAT)) $display("FAIL postreset_valid t=%0d: got %b want %b", t, valid_out, t == LAT);
      else pass_cnt++;
      if (t == LAT) begin
        total_cnt++;
        if (result !== 16'h4200) $display("FAIL postreset_result: got %h want 4200", result);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
